axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Shares the CPU's single AXI read port between the instruction-fetch interface and the data-read interface. Each requester presents a full AXI read-address/read-data master; the arbiter grants one at a time, forwards its AR beat downstream, and routes the R beats back until `RLAST`. It sits between the two RAM interfaces and the AXI crossbar/bridge, with exactly one read transaction outstanding at a time.

## Interface
- `INST_ID`, 4'h0: ARID driven downstream for instruction requests.
- `DATA_ID`, 4'h1: ARID driven downstream for data requests.
- `clk` in 1: clock; all logic is on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot` in 4/32/8/3/2/2/4/3: instruction AR payload.
- `i_arvalid` in 1 / `i_arready` out 1: instruction AR handshake.
- `i_rid/rdata/rresp/rlast` out 4/32/2/1: instruction R payload.
- `i_rvalid` out 1 / `i_rready` in 1: instruction R handshake.
- `d_*`: same set as `i_*`, for the data requester.
- `m_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot` out 4/32/8/3/2/2/4/3: downstream AR payload.
- `m_arvalid` out 1 / `m_arready` in 1: downstream AR handshake.
- `m_rid/rdata/rresp/rlast` in 4/32/2/1: downstream R payload.
- `m_rvalid` in 1 / `m_rready` out 1: downstream R handshake.

## Operation
- States: IDLE, AR_I, AR_D, R_I, R_D.
- **IDLE**
  - No request: stay in IDLE.
  - Only `i_arvalid`: go to AR_I. Only `d_arvalid`: go to AR_D.
  - Both valid: grant follows the policy in Configuration.
- **AR_x**
  - `m_ar*` = granted master's payload, except `m_arid` = INST_ID or DATA_ID.
  - `m_arvalid` = 1; granted `x_arready` = `m_arready`; the other `arready` = 0.
  - On `m_arvalid && m_arready`: go to R_x.
- **R_x**
  - `x_rvalid` = `m_rvalid`; `m_rready` = `x_rready`.
  - `x_rdata/rresp/rlast` = `m_*`.
  - `x_rid` = the ID the requester issued, latched at grant.
  - Other requester: `rvalid` = 0.
  - On `m_rvalid && m_rready && m_rlast`: go to IDLE.
- **Routing**
  - Routing is by state only; `m_rid` is ignored, and a mismatched `m_rid` is still routed to the owner.
  - `m_rresp` errors pass through unchanged. The arbiter performs no retry.
- **Requester obligations**
  - Hold AR payload stable while `arvalid` is high (AXI rule); the arbiter does not register the payload.
  - A requester that deasserts `arvalid` in IDLE before grant is simply not granted.
- **Reset**
  - All state is cleared asynchronously.
  - Outputs: state = IDLE; `m_arvalid`, `m_rready`, `i_arready`, `d_arready`, `i_rvalid`, `d_rvalid` = 0; all payload outputs = 0.
  - Reset mid-transaction abandons it. The downstream slave shares `resetn`.

## Timing
- Grant latency: `x_arvalid` high in IDLE at cycle N gives `m_arvalid` = 1 at N+1.
- AR pass-through: `arready` is combinational from `m_arready`.
- R pass-through: `rvalid`/`rdata` are combinational from `m_r*`; `m_rready` is combinational from the owner's `rready`. Zero added latency.
- Back-to-back: the last R beat at cycle N means IDLE at N+1, so the earliest next `m_arvalid` is N+2.
- Bursts: ARLEN+1 beats are accepted. The state is left only on the beat with `m_rlast` = 1, regardless of beat count.
- `m_rvalid` outside R_x: `m_rready` = 0 and nothing is forwarded.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - Defined: a 1-bit `last_grant` register (reset: data). On a simultaneous request, the requester not equal to `last_grant` wins; `last_grant` updates on every grant.
  - Undefined: fixed priority, data over instruction; `last_grant` is not built.

## Test plan
- Single inst fetch: `i_araddr`=0xBFC00000, ARLEN=0; `m_arready` after 2 cycles; one R beat with `rdata`=0x3C080001 and `rlast`=1.
  - `m_arid`=0 and `m_araddr`=0xBFC00000.
  - `i_rvalid`=1 with 0x3C080001; `d_rvalid` stays 0.
  - IDLE on the next cycle.
- Simultaneous requests: `i_araddr`=0x1000 and `d_araddr`=0x2000 both in IDLE for three rounds.
  - Without macro: order D, D, D while `d_arvalid` stays high.
  - With `ARB_ROUND_ROBIN_EN`: order I, D, I (first grant is inst, since `last_grant` resets to data).
- Burst: data ARLEN=3, with `d_rready` low during beat 2.
  - Four beats are delivered in order, and `m_rready` mirrors the stall.
  - No grant is made to inst until the beat with `rlast`.
- ID mismatch: inst transaction outstanding, downstream returns `m_rid`=4'h1 with `rlast`.
  - Beat goes to the instruction side with `i_rid` = issued ID.
- Reset mid-burst: `resetn` low asynchronously between clock edges during R_D beat 1.
  - All valid/ready outputs are 0 immediately, with state IDLE.
  - After release, a new inst request is granted at N+1.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read port between instruction and data masters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise data has fixed priority.
module axi_read_arbiter #(
    parameter logic [3:0] INST_ID = 4'h0,
    parameter logic [3:0] DATA_ID = 4'h1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  i_arid,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic [1:0]  i_arburst,
    input  logic [1:0]  i_arlock,
    input  logic [3:0]  i_arcache,
    input  logic [2:0]  i_arprot,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [3:0]  i_rid,
    output logic [31:0] i_rdata,
    output logic [1:0]  i_rresp,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [3:0]  d_arid,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic [1:0]  d_arburst,
    input  logic [1:0]  d_arlock,
    input  logic [3:0]  d_arcache,
    input  logic [2:0]  d_arprot,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [3:0]  d_rid,
    output logic [31:0] d_rdata,
    output logic [1:0]  d_rresp,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic [1:0]  m_arlock,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready
);
    localparam logic [2:0] IDLE = 3'd0, AR_I = 3'd1, AR_D = 3'd2, R_I = 3'd3, R_D = 3'd4;
    logic [2:0] state_q, state_d;
    logic [3:0] id_q, id_d;
    logic       gnt_data, grant, ar_i, ar_d, r_i, r_d;
    logic       unused_rid;
    // Routing is purely by state, so the returned ID is deliberately ignored.
    assign unused_rid = ^m_rid;
    assign grant = state_q == IDLE && (i_arvalid || d_arvalid);
    assign ar_i = state_q == AR_I;
    assign ar_d = state_q == AR_D;
    assign r_i = state_q == R_I;
    assign r_d = state_q == R_D;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign gnt_data = d_arvalid && (!i_arvalid || !last_q);
    assign last_d = grant ? gnt_data : last_q;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) last_q <= 1'b1;
        else last_q <= last_d;
`else
    assign gnt_data = d_arvalid;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_data ? AR_D : i_arvalid ? AR_I : IDLE;
            AR_I:    state_d = m_arready ? R_I : AR_I;
            AR_D:    state_d = m_arready ? R_D : AR_D;
            R_I:     state_d = (m_rvalid && i_rready && m_rlast) ? IDLE : R_I;
            R_D:     state_d = (m_rvalid && d_rready && m_rlast) ? IDLE : R_D;
            default: state_d = IDLE;
        endcase
    end
    assign id_d = grant ? (gnt_data ? d_arid : i_arid) : id_q;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    assign m_arvalid = ar_i || ar_d;
    assign m_arid    = ar_i ? INST_ID : ar_d ? DATA_ID : '0;
    assign m_araddr  = ar_i ? i_araddr : ar_d ? d_araddr : '0;
    assign m_arlen   = ar_i ? i_arlen : ar_d ? d_arlen : '0;
    assign m_arsize  = ar_i ? i_arsize : ar_d ? d_arsize : '0;
    assign m_arburst = ar_i ? i_arburst : ar_d ? d_arburst : '0;
    assign m_arlock  = ar_i ? i_arlock : ar_d ? d_arlock : '0;
    assign m_arcache = ar_i ? i_arcache : ar_d ? d_arcache : '0;
    assign m_arprot  = ar_i ? i_arprot : ar_d ? d_arprot : '0;
    assign i_arready = ar_i && m_arready;
    assign d_arready = ar_d && m_arready;
    assign m_rready  = r_i ? i_rready : r_d ? d_rready : 1'b0;
    assign i_rvalid  = r_i && m_rvalid;
    assign i_rid     = r_i ? id_q : '0;
    assign i_rdata   = r_i ? m_rdata : '0;
    assign i_rresp   = r_i ? m_rresp : '0;
    assign i_rlast   = r_i && m_rlast;
    assign d_rvalid  = r_d && m_rvalid;
    assign d_rid     = r_d ? id_q : '0;
    assign d_rdata   = r_d ? m_rdata : '0;
    assign d_rresp   = r_d ? m_rresp : '0;
    assign d_rlast   = r_d && m_rlast;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed self-checking bench for axi_read_arbiter.
// Expected grant order follows ARB_ROUND_ROBIN_EN when the macro is defined for the build.
module tb_axi_read_arbiter;
    logic        clk, resetn;
    logic [3:0]  i_arid, d_arid, m_arid, i_rid, d_rid, m_rid;
    logic [31:0] i_araddr, d_araddr, m_araddr, i_rdata, d_rdata, m_rdata;
    logic [7:0]  i_arlen, d_arlen, m_arlen;
    logic [2:0]  i_arsize, d_arsize, m_arsize, i_arprot, d_arprot, m_arprot;
    logic [1:0]  i_arburst, d_arburst, m_arburst, i_arlock, d_arlock, m_arlock;
    logic [3:0]  i_arcache, d_arcache, m_arcache;
    logic [1:0]  i_rresp, d_rresp, m_rresp;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    int checks = 0;
    int errors = 0;

    axi_read_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arlock(i_arlock), .i_arcache(i_arcache), .i_arprot(i_arprot),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_rid(i_rid), .i_rdata(i_rdata),
        .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_arid(d_arid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arburst(d_arburst), .d_arlock(d_arlock), .d_arcache(d_arcache), .d_arprot(d_arprot),
        .d_arvalid(d_arvalid), .d_arready(d_arready), .d_rid(d_rid), .d_rdata(d_rdata),
        .d_rresp(d_rresp), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = 3'd2; i_arburst = 2'd1;
        i_arlock = '0; i_arcache = '0; i_arprot = '0; i_arvalid = 0; i_rready = 0;
        d_arid = '0; d_araddr = '0; d_arlen = '0; d_arsize = 3'd2; d_arburst = 2'd1;
        d_arlock = '0; d_arcache = '0; d_arprot = '0; d_arvalid = 0; d_rready = 0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
        step(); step();
        checks++;
        if ({m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000",
                {m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid});
        end
        checks++;
        if (m_araddr !== 32'h0 || m_arid !== 4'h0) begin
            errors++; $display("FAIL reset_payload got addr %h id %h want 0", m_araddr, m_arid);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        i_arid = 4'h5; i_araddr = 32'hBFC00000; i_arlen = 8'd0; i_arvalid = 1;
        step();
        #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_arid !== 4'h0 || m_araddr !== 32'hBFC00000) begin
            errors++; $display("FAIL single_ar got v %b id %h addr %h want 1 0 bfc00000",
                m_arvalid, m_arid, m_araddr);
        end
        checks++;
        if (i_arready !== 1'b0) begin
            errors++; $display("FAIL single_arready_low got %b want 0", i_arready);
        end
        step();
        m_arready = 1;
        #1;
        checks++;
        if (i_arready !== 1'b1 || d_arready !== 1'b0) begin
            errors++; $display("FAIL single_arready got i %b d %b want 1 0", i_arready, d_arready);
        end
        step();
        i_arvalid = 0; m_arready = 0; i_rready = 1;
        m_rvalid = 1; m_rdata = 32'h3C080001; m_rlast = 1; m_rid = 4'h0;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h3C080001 || i_rid !== 4'h5 || i_rlast !== 1'b1) begin
            errors++; $display("FAIL single_r got v %b data %h id %h last %b want 1 3c080001 5 1",
                i_rvalid, i_rdata, i_rid, i_rlast);
        end
        checks++;
        if (d_rvalid !== 1'b0 || m_rready !== 1'b1) begin
            errors++; $display("FAIL single_route got d_rvalid %b m_rready %b want 0 1", d_rvalid, m_rready);
        end
        step();
        #1;
        checks++;
        if (m_rready !== 1'b0 || i_rvalid !== 1'b0 || m_arvalid !== 1'b0) begin
            errors++; $display("FAIL single_idle got m_rready %b i_rvalid %b m_arvalid %b want 0 0 0",
                m_rready, i_rvalid, m_arvalid);
        end
        m_rvalid = 0; m_rlast = 0; i_rready = 0;
        step();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_id[3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_id[0] = 4'h0; exp_id[1] = 4'h1; exp_id[2] = 4'h0;
`else
        exp_id[0] = 4'h1; exp_id[1] = 4'h1; exp_id[2] = 4'h1;
`endif
        i_araddr = 32'h1000; d_araddr = 32'h2000; i_arid = 4'h2; d_arid = 4'h9;
        i_arvalid = 1; d_arvalid = 1; m_arready = 1; i_rready = 1; d_rready = 1;
        for (int r = 0; r < 3; r++) begin
            step();
            checks++;
            if (m_arvalid !== 1'b1 || m_arid !== exp_id[r]
                || m_araddr !== (exp_id[r] == 4'h1 ? 32'h2000 : 32'h1000)) begin
                errors++; $display("FAIL simul_grant%0d got v %b id %h addr %h want id %h",
                    r, m_arvalid, m_arid, m_araddr, exp_id[r]);
            end
            step();
            m_rvalid = 1; m_rlast = 1; m_rdata = 32'hA0 + r;
            #1;
            checks++;
            if (i_rvalid !== (exp_id[r] == 4'h0) || d_rvalid !== (exp_id[r] == 4'h1)) begin
                errors++; $display("FAIL simul_rroute%0d got i %b d %b for id %h", r, i_rvalid, d_rvalid, exp_id[r]);
            end
            step();
            m_rvalid = 0; m_rlast = 0;
            checks++;
            if (m_arvalid !== 1'b0) begin
                errors++; $display("FAIL simul_b2b_idle%0d got m_arvalid %b want 0", r, m_arvalid);
            end
        end
        i_arvalid = 0; d_arvalid = 0; m_arready = 0;
        step();
    endtask

    task automatic test_burst();
        d_arid = 4'h7; d_araddr = 32'h3000; d_arlen = 8'd3; d_arvalid = 1;
        i_arid = 4'h3; i_araddr = 32'h4000; i_arvalid = 1; m_arready = 1; d_rready = 1;
        step();
        checks++;
        if (m_arid !== 4'h1 || m_arlen !== 8'd3 || i_arready !== 1'b0 || d_arready !== 1'b1) begin
            errors++; $display("FAIL burst_ar got id %h len %0d i_rdy %b d_rdy %b want 1 3 0 1",
                m_arid, m_arlen, i_arready, d_arready);
        end
        step();
        d_arvalid = 0; m_arready = 0;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1; m_rdata = 32'hD0000000 + k; m_rlast = (k == 3);
            if (k == 1) begin
                d_rready = 0;
                #1;
                checks++;
                if (m_rready !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'hD0000001) begin
                    errors++; $display("FAIL burst_stall got m_rready %b d_rvalid %b data %h want 0 1 d0000001",
                        m_rready, d_rvalid, d_rdata);
                end
                step();
                d_rready = 1;
            end
            #1;
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== 32'hD0000000 + k || m_rready !== 1'b1
                || d_rid !== 4'h7 || d_rlast !== (k == 3)) begin
                errors++; $display("FAIL burst_beat%0d got v %b data %h rdy %b id %h last %b",
                    k, d_rvalid, d_rdata, m_rready, d_rid, d_rlast);
            end
            checks++;
            if (m_arvalid !== 1'b0 || i_rvalid !== 1'b0) begin
                errors++; $display("FAIL burst_nogrant%0d got m_arvalid %b i_rvalid %b want 0 0", k, m_arvalid, i_rvalid);
            end
            step();
        end
        m_rvalid = 0; m_rlast = 0;
        checks++;
        if (m_arvalid !== 1'b0) begin
            errors++; $display("FAIL burst_end_idle got m_arvalid %b want 0", m_arvalid);
        end
        step();
        checks++;
        if (m_arvalid !== 1'b1 || m_arid !== 4'h0 || m_araddr !== 32'h4000) begin
            errors++; $display("FAIL burst_next_inst got v %b id %h addr %h want 1 0 4000", m_arvalid, m_arid, m_araddr);
        end
    endtask

    task automatic test_id_mismatch();
        m_arready = 1;
        step();
        i_arvalid = 0; m_arready = 0; i_rready = 1;
        m_rvalid = 1; m_rid = 4'h1; m_rlast = 1; m_rdata = 32'hCAFE0001; m_rresp = 2'b10;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rid !== 4'h3 || i_rresp !== 2'b10 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL idmis_route got i_v %b i_rid %h resp %b d_v %b want 1 3 10 0",
                i_rvalid, i_rid, i_rresp, d_rvalid);
        end
        step();
        m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rid = 0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        d_arlen = 8'd3; d_arvalid = 1; m_arready = 1; d_rready = 1;
        step();
        step();
        d_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rlast = 0; m_rdata = 32'h55;
        #1;
        checks++;
        if (d_rvalid !== 1'b1) begin
            errors++; $display("FAIL rst_pre got d_rvalid %b want 1", d_rvalid);
        end
        #1;
        resetn = 0;
        #1;
        checks++;
        if ({m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid} !== 6'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_async got %b data %h want 000000 0",
                {m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid}, d_rdata);
        end
        m_rvalid = 0;
        step();
        resetn = 1; i_arvalid = 1; i_araddr = 32'h8000;
        step();
        checks++;
        if (m_arvalid !== 1'b1 || m_arid !== 4'h0 || m_araddr !== 32'h8000) begin
            errors++; $display("FAIL rst_regrant got v %b id %h addr %h want 1 0 8000", m_arvalid, m_arid, m_araddr);
        end
        i_arvalid = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_burst();
        test_id_mismatch();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
